// File: rtl/up_sample_sched_ctrl.sv
// Schedule controller for a 2x nearest-neighbour up-sampler: loads an IN_H x IN_W
// frame, sweeps the 2*IN_H x 2*IN_W compute raster, then drains it to the consumer.
module up_sample_sched_ctrl #(
  parameter int IN_W = 64,
  parameter int IN_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in_wen,
  output logic [2:0][15:0] in_ctrl_vars,
  output logic             nn_ren,
  output logic             nn_wen,
  output logic [2:0][15:0] nn_ctrl_vars,
  output logic             out_ren,
  output logic [2:0][15:0] out_ctrl_vars,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] IN_COL_LAST  = 16'(IN_W - 1);
  localparam logic [15:0] IN_ROW_LAST  = 16'(IN_H - 1);
  localparam logic [15:0] OUT_COL_LAST = 16'(2 * IN_W - 1);
  localparam logic [15:0] OUT_ROW_LAST = 16'(2 * IN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;

  logic        adv;
  logic [15:0] col_last;
  logic [15:0] row_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // One row/col counter pair is reused by every phase; only the wrap limits differ.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    in_ready  = 1'b0;
    in_wen    = 1'b0;
    nn_ren    = 1'b0;
    nn_wen    = 1'b0;
    out_ren   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    adv       = 1'b0;
    col_last  = OUT_COL_LAST;
    row_last  = OUT_ROW_LAST;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        in_wen   = in_valid;
        adv      = in_valid;
        col_last = IN_COL_LAST;
        row_last = IN_ROW_LAST;
      end
      S_COMPUTE: begin
        nn_ren = 1'b1;
        nn_wen = 1'b1;
        adv    = 1'b1;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_ren   = 1'b1;
        adv       = out_ready;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (col_q == col_last) begin
        col_d = '0;
        if (row_q == row_last) begin
          row_d = '0;
          case (state_q)
            S_LOAD:    state_d = S_COMPUTE;
            S_COMPUTE: state_d = S_DRAIN;
            default:   state_d = S_DONE;
          endcase
        end else begin
          row_d = row_q + 16'd1;
        end
      end else begin
        col_d = col_q + 16'd1;
      end
    end

    // Abort wins over every transition, including a completing handshake.
    if (flush) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
    end
  end

  assign busy = (state_q != S_IDLE);

  assign in_ctrl_vars  = (state_q == S_LOAD)    ? {col_q, row_q, 16'd0} : '0;
  assign nn_ctrl_vars  = (state_q == S_COMPUTE) ? {col_q, row_q, 16'd0} : '0;
  assign out_ctrl_vars = (state_q == S_DRAIN)   ? {col_q, row_q, 16'd0} : '0;

endmodule

// File: tb/tb_up_sample_sched_ctrl.sv
// Bench for up_sample_sched_ctrl at IN_W=IN_H=4: phase/index model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_up_sample_sched_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NI = W * H;
  localparam int NO = 4 * W * H;

  logic clk = 1'b0;
  logic rst, flush, start, in_valid, out_ready;
  logic in_ready, in_wen, nn_ren, nn_wen, out_ren, out_valid, busy, done;
  logic [2:0][15:0] in_cv, nn_cv, out_cv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  up_sample_sched_ctrl #(.IN_W(W), .IN_H(H)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_ctrl_vars(in_cv),
    .nn_ren(nn_ren), .nn_wen(nn_wen), .nn_ctrl_vars(nn_cv),
    .out_ren(out_ren), .out_ctrl_vars(out_cv), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 compute, 3 drain, 4 done; idx is a linear raster index.
  int ph, idx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph  <= 0;
      idx <= 0;
    end else if (flush) begin
      ph  <= 0;
      idx <= 0;
    end else begin
      case (ph)
        0: if (start) begin ph <= 1; idx <= 0; end
        1: if (in_valid) begin
             if (idx + 1 == NI) begin ph <= 2; idx <= 0; end else idx <= idx + 1;
           end
        2: if (idx + 1 == NO) begin ph <= 3; idx <= 0; end else idx <= idx + 1;
        3: if (out_ready) begin
             if (idx + 1 == NO) begin ph <= 4; idx <= 0; end else idx <= idx + 1;
           end
        default: ph <= 0;
      endcase
    end
  end

  int n_wen, n_nn, n_hs, n_done;
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(ph == 1));
    chk("in_wen", int'(in_wen), int'(ph == 1 && in_valid));
    chk("nn_ren", int'(nn_ren), int'(ph == 2));
    chk("nn_wen", int'(nn_wen), int'(ph == 2));
    chk("out_valid", int'(out_valid), int'(ph == 3));
    chk("out_ren", int'(out_ren), int'(ph == 3));
    chk("busy", int'(busy), int'(ph != 0));
    chk("done", int'(done), int'(ph == 4));
    chk("cv0_zero", int'(in_cv[0] | nn_cv[0] | out_cv[0]), 0);
    if (ph == 1) begin
      chk("in_row", int'(in_cv[1]), idx / W);
      chk("in_col", int'(in_cv[2]), idx % W);
    end
    if (ph == 2) begin
      chk("nn_row", int'(nn_cv[1]), idx / (2 * W));
      chk("nn_col", int'(nn_cv[2]), idx % (2 * W));
    end
    if (ph == 3) begin
      chk("out_row", int'(out_cv[1]), idx / (2 * W));
      chk("out_col", int'(out_cv[2]), idx % (2 * W));
    end
    if (in_wen) n_wen++;
    if (nn_wen && nn_ren) n_nn++;
    if (out_valid && out_ready) n_hs++;
    if (done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_wen = 0; n_nn = 0; n_hs = 0; n_done = 0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 1000) begin step(); g++; end
    if (g >= 1000) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int cycles, lc, g;
    rst = 1'b1; flush = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_counts();
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    step();

    // Nominal frame
    $display("txn nominal frame");
    in_valid = 1'b1; out_ready = 1'b1;
    clr_counts();
    start = 1'b1; step(); start = 1'b0;
    cycles = 1;
    while (busy && cycles < 1000) begin step(); cycles++; end
    chk("nom_cycles", cycles, 146);
    chk("nom_wen", n_wen, 16);
    chk("nom_nn", n_nn, 64);
    chk("nom_hs", n_hs, 64);
    chk("nom_done", n_done, 1);

    // Input gaps, compute wrap, drain backpressure
    $display("txn gaps/wrap/backpressure frame");
    clr_counts();
    in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    lc = 0;
    while (in_ready && lc < 200) begin in_valid = ~in_valid; step(); lc++; end
    in_valid = 1'b0;
    chk("gap_load_cycles", lc, 31);
    chk("gap_wen", n_wen, 16);
    g = 0;
    while (!(nn_wen && nn_cv[1] == 16'd2 && nn_cv[2] == 16'd7) && g < 200) begin step(); g++; end
    chk("wrap_found", int'(g < 200), 1);
    step();
    chk("wrap_row", int'(nn_cv[1]), 3);
    chk("wrap_col", int'(nn_cv[2]), 0);
    g = 0;
    while (!(out_valid && out_cv[1] == 16'd3 && out_cv[2] == 16'd5) && g < 200) begin step(); g++; end
    chk("bp_found", int'(g < 200), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_row", int'(out_cv[1]), 3);
      chk("bp_hold_col", int'(out_cv[2]), 5);
      chk("bp_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume_col", int'(out_cv[2]), 6);
    chk("bp_resume_row", int'(out_cv[1]), 3);
    wait_idle("bp");
    chk("bp_done", n_done, 1);
    chk("bp_hs", n_hs, 64);

    // Abort during compute
    $display("txn flush abort");
    clr_counts();
    in_valid = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    g = 0;
    while (!nn_wen && g < 200) begin step(); g++; end
    repeat (10) step();
    chk("abort_pre_row", int'(nn_cv[1]), 1);
    chk("abort_pre_col", int'(nn_cv[2]), 2);
    flush = 1'b1; step(); flush = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_nn", int'(nn_wen | nn_ren), 0);
    chk("abort_strobes", int'(in_ready | in_wen | out_valid | out_ren), 0);
    repeat (3) step();
    chk("abort_no_done", n_done, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("rerun_ready", int'(in_ready), 1);
    chk("rerun_row", int'(in_cv[1]), 0);
    chk("rerun_col", int'(in_cv[2]), 0);
    wait_idle("rerun");
    chk("rerun_done", n_done, 1);

    // Asynchronous reset mid-drain
    $display("txn async reset mid-drain");
    clr_counts();
    start = 1'b1; step(); start = 1'b0;
    g = 0;
    while (!out_valid && g < 300) begin step(); g++; end
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_out", int'(out_valid | out_ren), 0);
    chk("arst_cv", int'(out_cv[1] | out_cv[2]), 0);
    chk("arst_done", int'(done), 0);
    start = 1'b1;
    step();
    chk("arst_start_ignored", int'(busy), 0);
    rst = 1'b0;
    step();
    chk("post_rst_start", int'(busy), 1);
    start = 1'b0;
    wait_idle("post_rst");
    chk("post_rst_done", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
